// File: rtl/rv32i_exec_unit_if.sv
// Decode-to-execute request and execute result bundle for rv32i_exec_unit.
// The master drives an instruction with its operands; the slave returns registered results.
interface rv32i_exec_unit_if;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic [31:0] imm;
  logic [31:0] alu_res;
  logic        br_taken;
  logic [31:0] br_target;
  logic        illegal;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data,
    input  out_valid, imm, alu_res, br_taken, br_target, illegal
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data,
    output out_valid, imm, alu_res, br_taken, br_target, illegal
  );
endinterface

// File: rtl/rv32i_exec_unit.sv
// Registered RV32I execute stage: immediate decode, integer ALU, branch/jump resolution.
// Define EXEC_ILLEGAL_CHECK_EN to flag unsupported encodings and suppress their results.
module rv32i_exec_unit #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              rst_n,
  rv32i_exec_unit_if.slave bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            alt;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;

  assign instr  = bus.instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  // funct7[5] selects SUB/SRA; the remaining funct7 bits only matter for legality.
  assign alt    = instr[30];
  assign op_a   = bus.rs1_data;

  logic [XLEN-1:0] imm_c;

  always_comb begin
    imm_c = '0;
    case (opcode)
      OP_LOAD, OP_ALUI, OP_JALR, OP_SYSTEM:
        imm_c = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:
        imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_c = {instr[31:12], 12'b0};
      OP_JAL:
        imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm_c = '0;
    endcase
  end

  // Branches also have opcode[5]=1, so op_b is rs2 there and the comparators are shared.
  assign op_b  = opcode[5] ? bus.rs2_data : imm_c;
  assign shamt = op_b[4:0];

  logic            eq_c;
  logic            lt_s_c;
  logic            lt_u_c;
  logic [XLEN-1:0] sra_c;

  assign eq_c   = (op_a == op_b);
  assign lt_s_c = ($signed(op_a) < $signed(op_b));
  assign lt_u_c = (op_a < op_b);
  assign sra_c  = $unsigned($signed(op_a) >>> shamt);

  logic [XLEN-1:0] alu_c;

  always_comb begin
    alu_c = '0;
    case (funct3)
      3'b000:  alu_c = (opcode == OP_ALU && alt) ? (op_a - op_b) : (op_a + op_b);
      3'b001:  alu_c = op_a << shamt;
      3'b010:  alu_c = {{(XLEN-1){1'b0}}, lt_s_c};
      3'b011:  alu_c = {{(XLEN-1){1'b0}}, lt_u_c};
      3'b100:  alu_c = op_a ^ op_b;
      3'b101:  alu_c = alt ? sra_c : (op_a >> shamt);
      3'b110:  alu_c = op_a | op_b;
      default: alu_c = op_a & op_b;
    endcase
  end

  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] rs1_imm;
  logic [XLEN-1:0] pc_plus4;

  assign pc_imm   = bus.pc + imm_c;
  assign rs1_imm  = op_a + imm_c;
  assign pc_plus4 = bus.pc + 32'd4;

  logic [XLEN-1:0] res_c;
  logic            taken_c;
  logic [XLEN-1:0] target_c;

  always_comb begin
    res_c    = '0;
    taken_c  = 1'b0;
    target_c = pc_plus4;
    case (opcode)
      OP_ALU, OP_ALUI:   res_c = alu_c;
      OP_LOAD, OP_STORE: res_c = rs1_imm;
      OP_LUI:            res_c = imm_c;
      OP_AUIPC:          res_c = pc_imm;
      OP_JAL: begin
        res_c    = pc_plus4;
        taken_c  = 1'b1;
        target_c = pc_imm;
      end
      OP_JALR: begin
        res_c    = pc_plus4;
        taken_c  = 1'b1;
        target_c = {rs1_imm[XLEN-1:1], 1'b0};
      end
      OP_BRANCH: begin
        target_c = pc_imm;
        case (funct3)
          3'b000:  taken_c = eq_c;
          3'b001:  taken_c = !eq_c;
          3'b100:  taken_c = lt_s_c;
          3'b101:  taken_c = !lt_s_c;
          3'b110:  taken_c = lt_u_c;
          3'b111:  taken_c = !lt_u_c;
          default: taken_c = 1'b0;
        endcase
      end
      default: begin
        res_c   = '0;
        taken_c = 1'b0;
      end
    endcase
  end

  logic [XLEN-1:0] res_fin;
  logic            taken_fin;

`ifdef EXEC_ILLEGAL_CHECK_EN
  logic [6:0] funct7;
  logic       ill_c;
  logic       illegal_q;

  assign funct7 = instr[31:25];

  always_comb begin
    ill_c = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI,
      OP_AUIPC, OP_SYSTEM, OP_FENCE:
        ill_c = 1'b0;
      OP_BRANCH:
        ill_c = (funct3 == 3'b010) || (funct3 == 3'b011);
      OP_ALU:
        ill_c = (funct7 != 7'b0000000) &&
                !((funct7 == 7'b0100000) && (funct3 == 3'b000 || funct3 == 3'b101));
      OP_ALUI: begin
        if (funct3 == 3'b001)
          ill_c = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          ill_c = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        else
          ill_c = 1'b0;
      end
      default:
        ill_c = 1'b1;
    endcase
  end

  assign res_fin   = ill_c ? '0 : res_c;
  assign taken_fin = ill_c ? 1'b0 : taken_c;

  always_ff @(posedge clk) begin
    if (!rst_n)
      illegal_q <= 1'b0;
    else if (bus.in_valid)
      illegal_q <= ill_c;
  end

  assign bus.illegal = illegal_q;
`else
  assign res_fin     = res_c;
  assign taken_fin   = taken_c;
  assign bus.illegal = 1'b0;
`endif

  logic            out_valid_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] alu_res_q;
  logic            br_taken_q;
  logic [XLEN-1:0] br_target_q;

  // Results hold while idle so downstream can keep reading the last instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      alu_res_q   <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        imm_q       <= imm_c;
        alu_res_q   <= res_fin;
        br_taken_q  <= taken_fin;
        br_target_q <= target_c;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.imm       = imm_q;
  assign bus.alu_res   = alu_res_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.br_target = br_target_q;

endmodule

// File: tb/tb_rv32i_exec_unit.sv
// Scoreboard bench for rv32i_exec_unit: directed plan vectors plus random instructions,
// checked against an instruction-level reference model.
module tb_rv32i_exec_unit;

  logic clk;
  logic rst_n;

  rv32i_exec_unit_if bus ();

  rv32i_exec_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] imm;
    logic [31:0] alu;
    logic        taken;
    logic [31:0] target;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  logic started;
  int   checks;
  int   errors;

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << bits;
    return v[bits-1] ? (v | m) : (v & ~m);
  endfunction

  // Reference model: evaluates one instruction from its mnemonic-level meaning.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] y;
    logic signed [31:0] sa;
    int sh;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    e = '0;
    e.target = p + 4;
    if (op == 7'h03 || op == 7'h13 || op == 7'h67 || op == 7'h73)
      e.imm = sx({20'b0, i[31:20]}, 12);
    else if (op == 7'h23)
      e.imm = sx({20'b0, i[31:25], i[11:7]}, 12);
    else if (op == 7'h63)
      e.imm = sx({19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
    else if (op == 7'h37 || op == 7'h17)
      e.imm = {i[31:12], 12'b0};
    else if (op == 7'h6F)
      e.imm = sx({11'b0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
    if (op == 7'h33 || op == 7'h13) begin
      y = (op == 7'h33) ? b : e.imm;
      sh = int'(y % 32);
      sa = $signed(a) >>> sh;
      case (f3)
        3'd0: e.alu = (op == 7'h33 && f7[5]) ? a - y : a + y;
        3'd1: e.alu = a << sh;
        3'd2: e.alu = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
        3'd3: e.alu = (a < y) ? 32'd1 : 32'd0;
        3'd4: e.alu = a ^ y;
        3'd5: e.alu = f7[5] ? sa : (a >> sh);
        3'd6: e.alu = a | y;
        default: e.alu = a & y;
      endcase
    end
    else if (op == 7'h03 || op == 7'h23) e.alu = a + e.imm;
    else if (op == 7'h37) e.alu = e.imm;
    else if (op == 7'h17) e.alu = p + e.imm;
    else if (op == 7'h6F) begin
      e.alu = p + 4; e.taken = 1'b1; e.target = p + e.imm;
    end
    else if (op == 7'h67) begin
      e.alu = p + 4; e.taken = 1'b1; e.target = (a + e.imm) & 32'hFFFF_FFFE;
    end
    else if (op == 7'h63) begin
      e.target = p + e.imm;
      case (f3)
        3'd0: e.taken = (a == b);
        3'd1: e.taken = (a != b);
        3'd4: e.taken = $signed(a) < $signed(b);
        3'd5: e.taken = $signed(a) >= $signed(b);
        3'd6: e.taken = a < b;
        3'd7: e.taken = a >= b;
        default: e.taken = 1'b0;
      endcase
    end
`ifdef EXEC_ILLEGAL_CHECK_EN
    if (!(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F}))
      e.ill = 1'b1;
    else if (op == 7'h63 && (f3 == 3'd2 || f3 == 3'd3))
      e.ill = 1'b1;
    else if (op == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
      e.ill = 1'b1;
    else if (op == 7'h13 && f3 == 3'd1 && f7 != 7'h00)
      e.ill = 1'b1;
    else if (op == 7'h13 && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)
      e.ill = 1'b1;
    if (e.ill) begin
      e.alu = '0;
      e.taken = 1'b0;
    end
`endif
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] i,
                               input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    rst_n        = rst;
    bus.in_valid = v;
    bus.instr    = i;
    bus.pc       = p;
    bus.rs1_data = a;
    bus.rs2_data = b;
    if (rst && v)
      sb.push_back(model(i, p, a, b));
    @(posedge clk);
    #1;
  endtask

  // Monitor: reset bookkeeping on the rising edge, comparisons on the falling edge.
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (!rst_n) begin
        started = 1'b1;
        held    = '0;
      end
    end else if (started) begin
      if (bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          held = sb.pop_front();
          checkOutput("imm", bus.imm, held.imm);
          checkOutput("alu_res", bus.alu_res, held.alu);
          checkOutput("br_taken", {31'b0, bus.br_taken}, {31'b0, held.taken});
          checkOutput("br_target", bus.br_target, held.target);
          checkOutput("illegal", {31'b0, bus.illegal}, {31'b0, held.ill});
        end
      end else begin
        checkOutput("out_valid_low", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("hold_imm", bus.imm, held.imm);
        checkOutput("hold_alu_res", bus.alu_res, held.alu);
        checkOutput("hold_br_taken", {31'b0, bus.br_taken}, {31'b0, held.taken});
        checkOutput("hold_br_target", bus.br_target, held.target);
        checkOutput("hold_illegal", {31'b0, bus.illegal}, {31'b0, held.ill});
      end
    end
  end

  logic [6:0] ops [12];

  initial begin
    logic [31:0] ins;
    checks  = 0;
    errors  = 0;
    started = 1'b0;
    held    = '0;
    rst_n   = 1'b0;
    bus.in_valid = 1'b0;
    bus.instr    = '0;
    bus.pc       = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F, 7'h00};
    #1;

    // Reset with a valid instruction presented: it must be dropped.
    applyStimulus(1'b0, 1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7);
    applyStimulus(1'b0, 1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7);

    applyStimulus(1'b1, 1'b1, 32'h002081B3, 32'h0,  32'd5,        32'd7);
    applyStimulus(1'b1, 1'b1, 32'h402081B3, 32'h0,  32'd5,        32'd7);
    applyStimulus(1'b1, 1'b1, 32'h4040D193, 32'h0,  32'h80000000, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'hFE20AE23, 32'h0,  32'h100,      32'h55);
    applyStimulus(1'b1, 1'b1, 32'h123450B7, 32'h0,  32'h0,        32'h0);
    applyStimulus(1'b1, 1'b1, 32'hFE20CEE3, 32'h40, 32'hFFFFFFFF, 32'd1);
    applyStimulus(1'b1, 1'b1, 32'hFE20EEE3, 32'h40, 32'hFFFFFFFF, 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h003080E7, 32'h20, 32'h1001,     32'h0);
    applyStimulus(1'b1, 1'b1, 32'h008000EF, 32'h10, 32'h0,        32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0,        32'h0,  32'h0,        32'h0);
    applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, 32'h4,  32'h9,        32'h9);
    applyStimulus(1'b1, 1'b1, 32'h0000007F, 32'h0,  32'h3,        32'h4);

    for (int n = 0; n < 800; n++) begin
      int sel;
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 11)];
      if (ins[6:0] == 7'h00)
        ins[6:0] = 7'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0) ins[31:25] = 7'h00;
      else if (sel == 1) ins[31:25] = 7'h20;
      if ($urandom_range(0, 4) == 0)
        applyStimulus(1'b1, $urandom_range(0, 3) != 0, ins, $urandom, 32'h1234, 32'h1234);
      else
        applyStimulus($urandom_range(0, 60) != 0, $urandom_range(0, 4) != 0,
                      ins, $urandom, $urandom, $urandom);
    end

    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_exec_unit.md
Name: rv32i_exec_unit

Overview:
- Registered RV32I execute block that merges immediate decode, integer ALU and branch resolution.
- Sits between the core's decode stage (instruction, PC, register operands) and its memory/writeback stages.
- Produces the sign-extended immediate, the ALU/link/address result, and the branch decision and target, one cycle after each valid input.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  inputs valid this cycle; capture on the next rising edge.
- instr  in  32  instruction word.
- pc  in  32  address of instr.
- rs1_data  in  32  value of register rs1 (instr[19:15]).
- rs2_data  in  32  value of register rs2 (instr[24:20]).
- out_valid  out  1  registered in_valid.
- imm  out  32  decoded, sign-extended immediate.
- alu_res  out  32  result (see Behaviour).
- br_taken  out  1  redirect PC to br_target.
- br_target  out  32  redirect address.
- illegal  out  1  unsupported instruction flag (see Optional Feature).

Behaviour:
- Field decode: opcode=instr[6:0], funct3=instr[14:12], funct7=instr[31:25].
- Reset: when rst_n is low at a rising edge, every output clears to 0, including out_valid.
- Latency and capture:
  - Fixed 1-cycle latency.
  - At a rising edge with in_valid=1, all outputs load from combinational results computed on the current inputs, and out_valid goes to 1.
  - At a rising edge with in_valid=0, out_valid goes to 0 and all other outputs hold their previous values.
- Immediate decode, by opcode:
  - I-type, opcodes 0000011 (LOAD), 0010011 (ALUI), 1100111 (JALR), 1110011 (SYSTEM): sext(instr[31:20]).
  - S-type, opcode 0100011: sext({instr[31:25],instr[11:7]}).
  - B-type, opcode 1100011: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - U-type, opcodes 0110111 (LUI) and 0010111 (AUIPC): {instr[31:12],12'b0}.
  - J-type, opcode 1101111: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - Any other opcode: 0.
- ALU operands:
  - Operand A = rs1_data.
  - Operand B = rs2_data if opcode[5]=1 (R-type 0110011); imm if opcode[5]=0 (ALUI).
  - shamt = B[4:0].
- ALU operation, by funct3:
  - 000: ADD, or SUB only when opcode=0110011 and funct7[5]=1. ADDI is never SUB.
  - 001: SLL.
  - 010: SLT (signed, result 0/1).
  - 011: SLTU (unsigned, result 0/1).
  - 100: XOR.
  - 101: SRL, or SRA when funct7[5]=1. Applies to both R and I forms.
  - 110: OR.
  - 111: AND.
  - All arithmetic wraps modulo 2^32; no overflow flag.
- alu_res by opcode:
  - ALU/ALUI: ALU result.
  - LOAD/STORE: rs1_data+imm (effective address).
  - LUI: imm.
  - AUIPC: pc+imm.
  - JAL/JALR: pc+4 (link value).
  - All others: 0.
- Branch resolution, BRANCH opcode, by funct3:
  - 000 BEQ: A==B.
  - 001 BNE: A!=B.
  - 100 BLT: signed A<B.
  - 101 BGE: signed A>=B.
  - 110 BLTU: unsigned A<B.
  - 111 BGEU: unsigned A>=B.
  - 010/011: not taken.
  - br_target = pc+imm.
- Jumps:
  - JAL: br_taken=1, br_target=pc+imm.
  - JALR: br_taken=1, br_target=(rs1_data+imm)&32'hFFFFFFFE.
- Other opcodes: br_taken=0, br_target=pc+4.
- Mid-operation reset: reset has priority over capture. A transaction presented with in_valid=1 in a reset cycle is dropped.

Optional Feature:
- Macro: EXEC_ILLEGAL_CHECK_EN.
- When defined, illegal is registered with the other outputs. It is 1 when any of these holds:
  - opcode is not one of the 11 RV32I opcodes (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011, 0001111);
  - BRANCH with funct3 010 or 011;
  - R-type with funct7 not equal to 0000000, and not equal to 0100000 with funct3 000/101;
  - ALUI shift (funct3 001/101) with an illegal funct7.
- When illegal is 1, alu_res and br_taken are forced to 0.
- When not defined, illegal is tied to 0 and no checking logic exists.

Test Plan:
- Reset then ADD: rst_n=0 for 2 cycles then 1; instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, in_valid=1 → next cycle out_valid=1, alu_res=12, br_taken=0; during reset all outputs are 0.
- SUB and SRAI: instr=0x402081B3, rs1=5, rs2=7 → alu_res=0xFFFFFFFE. Then instr=0x4040D193 (srai x3,x1,4), rs1=0x80000000 → alu_res=0xF8000000, imm=0x404.
- Immediates: sw x2,-4(x1) with instr=0xFE20AE23 → imm=0xFFFFFFFC; with rs1=0x100, alu_res=0xFC. lui with instr=0x123450B7 → imm=alu_res=0x12345000.
- Branches: blt with instr=0xFE20CEE3, pc=0x40, rs1=0xFFFFFFFF, rs2=1 → br_taken=1, br_target=0x3C. The same operands with bltu with instr=0xFE20EEE3 → br_taken=0.
- Jumps: jalr with instr=0x003080E7, rs1=0x1001, pc=0x20 → br_taken=1, br_target=0x1004, alu_res=0x24. jal with instr=0x008000EF, pc=0x10 → br_target=0x18.
- Hold and illegal: in_valid=0 → out_valid=0, other outputs unchanged. With EXEC_ILLEGAL_CHECK_EN defined, instr=0x0000007F → illegal=1, alu_res=0.
